// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU arbiter and its compute core.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_AND = 4'b0000;
    localparam opcode_t OP_OR  = 4'b0001;
    localparam opcode_t OP_ADD = 4'b0010;
    localparam opcode_t OP_SUB = 4'b0110;
    localparam opcode_t OP_SLT = 4'b0111;
    localparam opcode_t OP_NOR = 4'b1100;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: WIDTH+1-bit compute on zero-extended operands, returns result and carry.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_SLT:  wide = {{WIDTH{1'b0}}, (a < b)};
            OP_NOR:  wide = {1'b0, ~(a | b)};
            default: wide = '0;
        endcase
    end

    // Only ADD/SUB produce a meaningful top bit; SUB borrow shows up as carry=1.
    assign result = wide[WIDTH-1:0];
    assign carry  = ((op == OP_ADD) || (op == OP_SUB)) ? wide[WIDTH] : 1'b0;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin issue of up to four requesters onto one shared ALU with a registered, tagged response.
// Optional grant locking (req_lock port) is enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_carry
);

    logic             rsp_valid_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_carry_reg;
    logic [ID_W-1:0]  ptr_reg;

    logic [NUM_REQ-1:0] eligible;
    logic               free;
    logic               issue;
    logic               hi_found;
    logic               lo_found;
    logic               grant_found;
    logic [ID_W-1:0]    hi_idx;
    logic [ID_W-1:0]    lo_idx;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_next;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    opcode_t            op_sel;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;

`ifdef ALU_ARB_LOCK_EN
    logic            lock_active_reg;
    logic [ID_W-1:0] lock_owner_reg;
    logic            lock_sel;

    // While locked, only the owner may compete, even if it is currently idle.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi] & (~lock_active_reg | (lock_owner_reg == ID_W'(gi)));
    end
`else
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi];
    end
`endif

    assign free = ~rsp_valid_reg | rsp_ready;

    // Circular search: first eligible at/after the pointer, else wrap to the lowest eligible.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
                if (!hi_found && (i >= int'(ptr_reg))) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign issue    = grant_found & free & ~rst;
    assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = issue & (grant_idx == ID_W'(gi));
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = OP_AND;
`ifdef ALU_ARB_LOCK_EN
        lock_sel = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                a_sel  = req_a[i*WIDTH +: WIDTH];
                b_sel  = req_b[i*WIDTH +: WIDTH];
                op_sel = opcode_t'(req_op[i*4 +: 4]);
`ifdef ALU_ARB_LOCK_EN
                lock_sel = req_lock[i];
`endif
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (a_sel),
        .b      (b_sel),
        .op     (op_sel),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_carry_reg  <= 1'b0;
            ptr_reg        <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_active_reg <= 1'b0;
            lock_owner_reg  <= '0;
`endif
        end else begin
            if (issue) begin
                rsp_valid_reg  <= 1'b1;
                rsp_id_reg     <= grant_idx;
                rsp_result_reg <= alu_result;
                rsp_zero_reg   <= (alu_result == '0);
                rsp_carry_reg  <= alu_carry;
`ifdef ALU_ARB_LOCK_EN
                // Pointer is frozen while a lock is taken and resumes after the releasing issue.
                if (lock_sel) begin
                    lock_active_reg <= 1'b1;
                    lock_owner_reg  <= grant_idx;
                end else begin
                    lock_active_reg <= 1'b0;
                    ptr_reg         <= ptr_next;
                end
`else
                ptr_reg <= ptr_next;
`endif
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_carry  = rsp_carry_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed test-plan phases plus randomized traffic vs a reference model.
module tb_alu_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*4-1:0]     req_op;
    logic [NUM_REQ-1:0]       req_lock;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_zero;
    logic                     rsp_carry;

    always #5 clk = ~clk;

    alu_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
`ifdef ALU_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry)
    );

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
    } rsp_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic             lock;
    } op_t;

    rsp_t exp_q[$];
    op_t  pend[NUM_REQ][$];

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;
    bit m_rsp_valid = 1'b0;
    bit m_locked    = 1'b0;
    int m_owner     = 0;
    bit m_hs[NUM_REQ];
    bit rand_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain arithmetic; returns {carry, result}.
    function automatic logic [WIDTH:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        longint unsigned s;
        case (op)
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b0010: begin
                s = longint'(a) + longint'(b);
                return {(s > 64'h0000_0000_FFFF_FFFF), a + b};
            end
            4'b0110: return {(b > a), a - b};
            4'b0111: return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
            4'b1100: return {1'b0, ~(a | b)};
            default: return '0;
        endcase
    endfunction

    // Model: predicts grant, handshake and response for the coming clock edge.
    always @(negedge clk) begin : model
        int g;
        int j;
        bit free;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [WIDTH:0] r;
        rsp_t e;
        if (!rst) begin
            chk("rsp_valid", rsp_valid, m_rsp_valid);
            free = !m_rsp_valid || rsp_ready;
            g = -1;
            if (free) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[j] && (!m_locked || j == m_owner)) g = j;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            for (int i = 0; i < NUM_REQ; i++) m_hs[i] = 1'b0;
            if (g >= 0) begin
                r = ref_alu(req_op[g*4 +: 4], req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
                e.id     = ID_W'(g);
                e.result = r[WIDTH-1:0];
                e.zero   = (r[WIDTH-1:0] == '0);
                e.carry  = r[WIDTH];
                exp_q.push_back(e);
                m_hs[g] = 1'b1;
`ifdef ALU_ARB_LOCK_EN
                if (req_lock[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end else begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % NUM_REQ;
                end
`else
                m_ptr = (g + 1) % NUM_REQ;
`endif
                m_rsp_valid = 1'b1;
            end else if (rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: whenever a response is presented, compare against the scoreboard head.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q[0];
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_result", rsp_result, e.result);
                chk("rsp_zero", rsp_zero, e.zero);
                chk("rsp_carry", rsp_carry, e.carry);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    $display("rsp id=%0d result=%08h zero=%0d carry=%0d", rsp_id, rsp_result, rsp_zero, rsp_carry);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'($urandom_range(0, 15));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic load_req(input int i, input op_t o);
        req_valid[i]          = 1'b1;
        req_a[i*WIDTH +: WIDTH] = o.a;
        req_b[i*WIDTH +: WIDTH] = o.b;
        req_op[i*4 +: 4]      = o.op;
        req_lock[i]           = o.lock;
    endtask

    // Advance one cycle; refill idle requesters from their directed queue or randomly.
    task automatic run_cycle();
        logic [3:0] opc_tab [8];
        op_t o;
        bit busy;
        opc_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy = req_valid[i] && !m_hs[i];
            if (!busy) begin
                if (pend[i].size() > 0) begin
                    load_req(i, pend[i].pop_front());
                end else if (rand_mode && $urandom_range(0, 3) != 0) begin
                    o.a    = rnd_operand();
                    o.b    = rnd_operand();
                    o.op   = opc_tab[$urandom_range(0, 7)];
                    o.lock = ($urandom_range(0, 7) == 0);
                    load_req(i, o);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end else if (rand_mode && $urandom_range(0, 15) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
        if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) m_hs[i] = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_lock  = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests pending to prove req_ready is held low.
        repeat (3) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, '0);
        chk("reset_rsp_result", rsp_result, '0);
        chk("reset_rsp_zero", rsp_zero, 1'b0);
        chk("reset_rsp_carry", rsp_carry, 1'b0);
        chk("reset_req_ready", req_ready, '0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester ADD overflow to zero.
        pend[0].push_back('{a: 32'hFFFF_FFFF, b: 32'h1, op: 4'b0010, lock: 1'b0});
        run_cycle();
        run_cycle();
        chk("add_valid", rsp_valid, 1'b1);
        chk("add_result", rsp_result, 32'h0);
        chk("add_zero", rsp_zero, 1'b1);
        chk("add_carry", rsp_carry, 1'b1);
        chk("add_id", rsp_id, 2'd0);

        // Both requesters continuously valid: alternating grants, SUB borrow and SLT.
        pend[0].push_back('{a: 32'd5, b: 32'd7, op: 4'b0110, lock: 1'b0});
        pend[0].push_back('{a: 32'hF0F0_1234, b: 32'h0FF0_FFFF, op: 4'b0000, lock: 1'b0});
        pend[0].push_back('{a: 32'd100, b: 32'd1, op: 4'b0110, lock: 1'b0});
        pend[1].push_back('{a: 32'd3, b: 32'd9, op: 4'b0111, lock: 1'b0});
        pend[1].push_back('{a: 32'd9, b: 32'd3, op: 4'b0111, lock: 1'b0});
        pend[1].push_back('{a: 32'hA000_0000, b: 32'h0000_0005, op: 4'b0001, lock: 1'b0});
        repeat (9) run_cycle();

        // Stall: response held, all requesters blocked, then drain-and-issue together.
        pend[0].push_back('{a: 32'd1, b: 32'd2, op: 4'b0010, lock: 1'b0});
        pend[0].push_back('{a: 32'd7, b: 32'd7, op: 4'b0110, lock: 1'b0});
        pend[1].push_back('{a: 32'd8, b: 32'd4, op: 4'b0010, lock: 1'b0});
        run_cycle();
        run_cycle();
        rsp_ready = 1'b0;
        repeat (3) run_cycle();
        chk("stall_req_ready", req_ready, '0);
        chk("stall_rsp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        repeat (6) run_cycle();

        // Undefined opcode and NOR of zeros.
        pend[0].push_back('{a: 32'h1234_5678, b: 32'h9ABC_DEF0, op: 4'b1111, lock: 1'b0});
        pend[1].push_back('{a: 32'h0, b: 32'h0, op: 4'b1100, lock: 1'b0});
        repeat (5) run_cycle();

`ifdef ALU_ARB_LOCK_EN
        // Lock: requester 1 keeps the grant while locked, requester 0 waits until release.
        pend[1].push_back('{a: 32'd1, b: 32'd1, op: 4'b0010, lock: 1'b1});
        pend[1].push_back('{a: 32'd2, b: 32'd2, op: 4'b0010, lock: 1'b1});
        pend[1].push_back('{a: 32'd3, b: 32'd3, op: 4'b0010, lock: 1'b1});
        pend[1].push_back('{a: 32'd4, b: 32'd4, op: 4'b0010, lock: 1'b0});
        repeat (3) pend[0].push_back('{a: 32'd9, b: 32'd1, op: 4'b0110, lock: 1'b0});
        repeat (12) run_cycle();
`endif

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        repeat (400) run_cycle();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) run_cycle();

        // Mid-stream reset while a response is held.
        pend[0].push_back('{a: 32'd6, b: 32'd6, op: 4'b0010, lock: 1'b0});
        rsp_ready = 1'b0;
        repeat (3) run_cycle();
        #2;
        rst = 1'b1;
        exp_q.delete();
        m_ptr       = 0;
        m_rsp_valid = 1'b0;
        m_locked    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_hs[i] = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_result", rsp_result, '0);
        load_req(0, '{a: 32'd2, b: 32'd3, op: 4'b0010, lock: 1'b0});
        load_req(1, '{a: 32'd5, b: 32'd1, op: 4'b0110, lock: 1'b0});
        rsp_ready = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, '0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_grant0", req_ready, 2'b01);
        repeat (6) run_cycle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and issue stage that shares the single 32-bit ALU datapath between up to four requesters, such as the execute stage, the branch-compare unit and the address generator. Each requester presents operands and a 4-bit opcode on a valid/ready channel. The block grants one request per cycle, computes the result through one combinational ALU core, and returns a registered, requester-tagged response on a shared valid/ready response channel.

## Interface
- WIDTH, 32: operand and result width
- NUM_REQ, 2: number of requesters (2..4)
- ID_W, 2: width of requester tag; must be at least clog2(NUM_REQ)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a pending operation
- req_ready  out  NUM_REQ  requester i granted this cycle (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at slice [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same slicing
- req_op  in  NUM_REQ*4  opcode, slice [i*4 +: 4]
- req_lock  in  NUM_REQ  hold grant for the next operation (present only with ALU_ARB_LOCK_EN)
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  ID_W  index of the requester that issued the operation
- rsp_result  out  WIDTH  low WIDTH bits of the operation result
- rsp_zero  out  1  rsp_result == 0
- rsp_carry  out  1  bit WIDTH of the (WIDTH+1)-bit ADD/SUB result; 0 for other ops

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A-B)
  - 0111 SLT, unsigned A<B, result 1 or 0
  - 1100 NOR
  - any other opcode: result 0, carry 0
- Arithmetic is performed at WIDTH+1 bits, operands zero-extended. SUB borrow appears as carry=1.
- Issue condition: free = !rsp_valid || rsp_ready.
- Grant is combinational. The lowest index at or after the priority pointer with req_valid=1 is granted, but only when free=1. Otherwise req_ready is all zeros.
- A handshake occurs on req_valid[i] & req_ready[i]. On a handshake:
  - the response register loads the result, zero flag, carry flag and id=i;
  - rsp_valid is set;
  - the pointer becomes (i+1) mod NUM_REQ.
- If rsp_valid & rsp_ready and there is no handshake in the same cycle, rsp_valid clears and the other response fields hold their values.
- Simultaneous drain and issue in the same cycle: the new result replaces the old one and rsp_valid stays 1.
- Requesters must hold operands stable until req_ready. Dropping req_valid before a grant is legal and discards the request.

## Timing
- Latency: result appears on rsp_* on the cycle after the handshake.
- Throughput: one operation per cycle while rsp_ready=1.
- rsp_ready=0 with rsp_valid=1 stalls all requesters (req_ready=0), and the response fields hold their values.
- Reset (asynchronous, any cycle): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_carry=0, pointer=0, lock cleared. An in-flight response is discarded.
- req_ready is 0 while rst=1.

## Configuration
- ALU_ARB_LOCK_EN defined:
  - the req_lock port exists;
  - a handshake by requester i with req_lock[i]=1 sets lock owner = i;
  - while a lock owner is set, only the owner can be granted, even if the owner is idle;
  - the lock is released by an owner handshake with req_lock=0;
  - the pointer does not advance while locked; it advances normally on the releasing handshake.
- ALU_ARB_LOCK_EN undefined: no req_lock port and pure round-robin.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR;
  - the 4-bit opcode typedef.
- One sub-module, alu_core: a combinational WIDTH+1-bit compute that returns result and carry. The arbiter instantiates it once, on the granted operands.

## Test plan
- Single requester: req0 ADD A=0xFFFFFFFF B=0x00000001 -> next cycle rsp_result=0, rsp_zero=1, rsp_carry=1, rsp_id=0.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. Check SUB 5-7: result 0xFFFFFFFE, carry=1. Check SLT 3<9: result 1.
- rsp_ready=0 for 3 cycles with rsp_valid=1 -> req_ready stays 0 and the response holds. Raising rsp_ready drains and issues the next request in the same cycle.
- Opcode 1111 -> rsp_result=0, rsp_zero=1, rsp_carry=0. NOR of 0 and 0 -> 0xFFFFFFFF.
- Assert rst mid-stream with rsp_valid=1 -> rsp_valid=0 immediately. After release, requester 0 is granted first.
- With ALU_ARB_LOCK_EN: req1 issues with lock=1 while req0 is valid -> req1 is granted on consecutive operations and req0 is starved. req1 issues with lock=0 -> req0 is granted next.
